// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the fetch-stage PC sequencer.
//   - ADDR_W  : default PC / address width
//   - PC_STEP : sequential fetch increment (one 32-bit instruction)
//   - state_e : fetch FSM state encoding
package pc_sequencer_pkg;

    localparam int unsigned ADDR_W  = 64;
    localparam int unsigned PC_STEP = 4;

    typedef enum logic [1:0] {
        StBoot  = 2'd0,
        StFetch = 2'd1,
        StHold  = 2'd2
    } state_e;

endpackage

// File: rtl/pc_sequencer_if.sv
// Instruction-memory request handshake between the fetch sequencer and imem.
//   imem_req   : fetch request (sequencer -> memory)
//   imem_addr  : fetch address (sequencer -> memory)
//   imem_ready : memory accepts the request this cycle (memory -> sequencer)
interface pc_sequencer_if
    import pc_sequencer_pkg::*;
#(
    parameter int unsigned AddrW = ADDR_W
);
    logic             imem_req;
    logic [AddrW-1:0] imem_addr;
    logic             imem_ready;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready
    );
endinterface

// File: rtl/pc_sequencer_shl2.sv
// Shift-left-by-2 unit: turns a word offset into a byte offset.
//   din  : word offset (sign-extended)
//   dout : din << 2, truncated to Width bits
module pc_sequencer_shl2 #(
    parameter int unsigned Width = 64
) (
    input  logic [Width-1:0] din,
    output logic [Width-1:0] dout
);
    assign dout = din << 2;
endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage controller: owns the PC, drives the imem request handshake,
// selects sequential or branch-target next PC, handles stalls and redirects.
//   clk, reset      : clock, asynchronous active-high reset
//   stall           : hazard unit holds fetch
//   br_valid/taken/uncond, br_pc, br_imm : branch resolution from EX
//   imem            : imem request handshake (master side)
//   if_pc, if_valid : accepted instruction PC / valid
//   flush           : registered one-cycle IF/ID squash pulse
//   misalign        : sticky flag, redirect from a misaligned branch PC
//   redirect_cnt    : saturating count of taken redirects
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int unsigned     AddrW   = ADDR_W,
    parameter logic [AddrW-1:0] ResetPc = '0,
    parameter int unsigned     CntW    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              br_valid,
    input  logic              br_taken,
    input  logic              br_uncond,
    input  logic [AddrW-1:0]  br_pc,
    input  logic [AddrW-1:0]  br_imm,
    pc_sequencer_if.master    imem,
    output logic [AddrW-1:0]  if_pc,
    output logic              if_valid,
    output logic              flush,
    output logic              misalign,
    output logic [CntW-1:0]   redirect_cnt
);
    state_e            state_q, state_d;
    logic [AddrW-1:0]  pc_q, pc_d;
    logic              flush_q;
    logic              misalign_q;
    logic [CntW-1:0]   cnt_q;

    logic              redirect_now;
    logic [AddrW-1:0]  br_offset;
    logic [AddrW-1:0]  target;
    logic              advance;

    assign redirect_now = br_valid && (br_taken || br_uncond);

    pc_sequencer_shl2 #(
        .Width (AddrW)
    ) u_shl2 (
        .din  (br_imm),
        .dout (br_offset)
    );

    // Modulo-2^AddrW wrap is intended.
    assign target = br_pc + br_offset;

    // Sequential advance only on an accepted, un-stalled, un-redirected fetch.
    assign advance = (state_q == StFetch) && imem.imem_ready && !stall && !redirect_now;

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StBoot;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; a redirect always lands in FETCH, overriding stall
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StBoot:  state_d = StFetch;
            StFetch: state_d = (!redirect_now && stall) ? StHold : StFetch;
            StHold:  state_d = (!redirect_now && stall) ? StHold : StFetch;
            default: state_d = StBoot;
        endcase
    end

    // FSM outputs
    always_comb begin
        imem.imem_req  = (state_q == StFetch);
        imem.imem_addr = pc_q;
        if_pc          = pc_q;
        if_valid       = (state_q == StFetch) && imem.imem_ready && !redirect_now;
    end

    // PC next-state: redirect > stall > handshake
    always_comb begin
        pc_d = pc_q;
        if (redirect_now) begin
            pc_d = target;
        end else if (advance) begin
            pc_d = pc_q + AddrW'(PC_STEP);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q       <= ResetPc;
            flush_q    <= 1'b0;
            misalign_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            pc_q    <= pc_d;
            flush_q <= redirect_now;
            if (redirect_now && (br_pc[1:0] != 2'b00)) begin
                misalign_q <= 1'b1;
            end
            if (redirect_now && !(&cnt_q)) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign flush        = flush_q;
    assign misalign     = misalign_q;
    assign redirect_cnt = cnt_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: reset, sequential fetch, imem back-pressure,
// stall/hold, redirects (stall override, wrap, back-to-back, misalign, in BOOT),
// ignored br_taken without br_valid, and asynchronous reset.
module tb_pc_sequencer;
    logic        clk;
    logic        reset;
    logic        stall;
    logic        br_valid;
    logic        br_taken;
    logic        br_uncond;
    logic [63:0] br_pc;
    logic [63:0] br_imm;
    logic [63:0] if_pc;
    logic        if_valid;
    logic        flush;
    logic        misalign;
    logic [31:0] redirect_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    pc_sequencer_if #(.AddrW(64)) imem_bus ();

    pc_sequencer #(
        .AddrW   (64),
        .ResetPc (64'h0),
        .CntW    (32)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .br_valid     (br_valid),
        .br_taken     (br_taken),
        .br_uncond    (br_uncond),
        .br_pc        (br_pc),
        .br_imm       (br_imm),
        .imem         (imem_bus),
        .if_pc        (if_pc),
        .if_valid     (if_valid),
        .flush        (flush),
        .misalign     (misalign),
        .redirect_cnt (redirect_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are then changed 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic no_branch();
        br_valid  = 1'b0;
        br_taken  = 1'b0;
        br_uncond = 1'b0;
        br_pc     = 64'h0;
        br_imm    = 64'h0;
    endtask

    initial begin
        reset = 1'b1;
        stall = 1'b0;
        no_branch();
        imem_bus.imem_ready = 1'b1;

        // Reset state
        #12;
        check_eq("rst_req", 64'(imem_bus.imem_req), 64'h0);
        check_eq("rst_valid", 64'(if_valid), 64'h0);
        check_eq("rst_flush", 64'(flush), 64'h0);
        check_eq("rst_misalign", 64'(misalign), 64'h0);
        check_eq("rst_cnt", 64'(redirect_cnt), 64'h0);
        check_eq("rst_addr", imem_bus.imem_addr, 64'h0);

        // BOOT bubble, then sequential fetch 0,4,8
        reset = 1'b0;
        #1;
        check_eq("boot_req", 64'(imem_bus.imem_req), 64'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            #1;
            check_eq($sformatf("seq_addr%0d", i), imem_bus.imem_addr, 64'(4 * i));
            check_eq($sformatf("seq_valid%0d", i), 64'(if_valid), 64'h1);
        end

        // imem not ready for 3 cycles at pc=8
        imem_bus.imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_eq($sformatf("bp_req%0d", i), 64'(imem_bus.imem_req), 64'h1);
            check_eq($sformatf("bp_addr%0d", i), imem_bus.imem_addr, 64'h8);
            check_eq($sformatf("bp_valid%0d", i), 64'(if_valid), 64'h0);
            step();
        end
        imem_bus.imem_ready = 1'b1;
        #1;
        check_eq("bp_accept_addr", imem_bus.imem_addr, 64'h8);
        check_eq("bp_accept_valid", 64'(if_valid), 64'h1);
        step();
        #1;
        check_eq("bp_next_addr", imem_bus.imem_addr, 64'hC);
        step();

        // Stall for 2 cycles at pc=16
        stall = 1'b1;
        #1;
        check_eq("st_fetch_addr", imem_bus.imem_addr, 64'h10);
        check_eq("st_fetch_req", 64'(imem_bus.imem_req), 64'h1);
        step();
        #1;
        check_eq("st_hold_req", 64'(imem_bus.imem_req), 64'h0);
        check_eq("st_hold_addr", imem_bus.imem_addr, 64'h10);
        step();
        stall = 1'b0;
        #1;
        check_eq("st_rel_req", 64'(imem_bus.imem_req), 64'h0);
        step();
        #1;
        check_eq("st_resume_req", 64'(imem_bus.imem_req), 64'h1);
        check_eq("st_resume_addr", imem_bus.imem_addr, 64'h10);

        // Unconditional redirect during stall: 0x100 + (-2 << 2) = 0xF8
        stall     = 1'b1;
        br_valid  = 1'b1;
        br_uncond = 1'b1;
        br_pc     = 64'h100;
        br_imm    = 64'hFFFF_FFFF_FFFF_FFFE;
        #1;
        check_eq("rd_same_valid", 64'(if_valid), 64'h0);
        step();
        no_branch();
        stall = 1'b0;
        #1;
        check_eq("rd_addr", imem_bus.imem_addr, 64'hF8);
        check_eq("rd_req", 64'(imem_bus.imem_req), 64'h1);
        check_eq("rd_flush", 64'(flush), 64'h1);
        check_eq("rd_cnt", 64'(redirect_cnt), 64'h1);
        step();
        #1;
        check_eq("rd_flush_clr", 64'(flush), 64'h0);
        check_eq("rd_next_addr", imem_bus.imem_addr, 64'hFC);

        // Conditional redirect wrapping to 0
        br_valid = 1'b1;
        br_taken = 1'b1;
        br_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
        br_imm   = 64'h1;
        step();
        // Back-to-back redirect from misaligned PC: 0x102 + (0x10 << 2) = 0x142
        br_pc  = 64'h102;
        br_imm = 64'h10;
        #1;
        check_eq("wrap_addr", imem_bus.imem_addr, 64'h0);
        check_eq("wrap_flush", 64'(flush), 64'h1);
        check_eq("wrap_cnt", 64'(redirect_cnt), 64'h2);
        check_eq("wrap_misalign", 64'(misalign), 64'h0);
        step();
        no_branch();
        #1;
        check_eq("b2b_addr", imem_bus.imem_addr, 64'h142);
        check_eq("b2b_flush", 64'(flush), 64'h1);
        check_eq("b2b_misalign", 64'(misalign), 64'h1);
        check_eq("b2b_cnt", 64'(redirect_cnt), 64'h3);
        step();

        // br_taken without br_valid is ignored; misalign stays set
        br_taken = 1'b1;
        br_pc    = 64'h200;
        br_imm   = 64'h8;
        #1;
        check_eq("sticky_flush", 64'(flush), 64'h0);
        check_eq("sticky_addr", imem_bus.imem_addr, 64'h146);
        step();
        no_branch();
        #1;
        check_eq("ign_addr", imem_bus.imem_addr, 64'h14A);
        check_eq("ign_cnt", 64'(redirect_cnt), 64'h3);
        check_eq("ign_misalign", 64'(misalign), 64'h1);

        // Asynchronous reset mid-FETCH, no clock edge in between
        #1;
        reset = 1'b1;
        #1;
        check_eq("arst_req", 64'(imem_bus.imem_req), 64'h0);
        check_eq("arst_valid", 64'(if_valid), 64'h0);
        check_eq("arst_addr", imem_bus.imem_addr, 64'h0);
        check_eq("arst_flush", 64'(flush), 64'h0);
        check_eq("arst_misalign", 64'(misalign), 64'h0);
        check_eq("arst_cnt", 64'(redirect_cnt), 64'h0);

        // Redirect captured in BOOT: 0x40 + (4 << 2) = 0x50
        step();
        reset     = 1'b0;
        br_valid  = 1'b1;
        br_taken  = 1'b1;
        br_pc     = 64'h40;
        br_imm    = 64'h4;
        #1;
        check_eq("boot_rd_req", 64'(imem_bus.imem_req), 64'h0);
        step();
        no_branch();
        #1;
        check_eq("boot_rd_addr", imem_bus.imem_addr, 64'h50);
        check_eq("boot_rd_req2", 64'(imem_bus.imem_req), 64'h1);
        check_eq("boot_rd_flush", 64'(flush), 64'h1);
        check_eq("boot_rd_cnt", 64'(redirect_cnt), 64'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Fetch-stage controller for the segmented ARMv8 core.
- Owns the program counter and drives the instruction-memory request handshake.
- Sequences next-PC selection: sequential PC+4, or a branch target computed as branch PC + (word offset << 2).
- Handles pipeline stalls and branch redirects, pulses the IF/ID flush, and keeps a saturating redirect counter.

Parameters:
- ADDR_W, 64, PC and address width.
- RESET_PC, 64'h0, PC value loaded by reset.
- CNT_W, 32, width of the redirect counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  hazard unit holds fetch.
- br_valid  in  1  a branch is resolved in EX this cycle.
- br_taken  in  1  conditional branch outcome; valid with br_valid.
- br_uncond  in  1  unconditional branch (B/BL); taken regardless of br_taken.
- br_pc  in  ADDR_W  PC of the resolving branch.
- br_imm  in  ADDR_W  sign-extended word offset, not yet shifted.
- imem_ready  in  1  instruction memory accepts the request this cycle.
- imem_req  out  1  fetch request.
- imem_addr  out  ADDR_W  fetch address; equals pc.
- if_pc  out  ADDR_W  PC of the instruction accepted this cycle.
- if_valid  out  1  imem_req && imem_ready && !redirect_now.
- flush  out  1  registered one-cycle pulse that squashes IF/ID.
- misalign  out  1  sticky error flag.
- redirect_cnt  out  CNT_W  count of taken redirects, saturating.

Behaviour:
- Reset values (asynchronous): pc=RESET_PC, state=BOOT, flush=0, misalign=0, redirect_cnt=0, imem_req=0, if_valid=0.
- Definitions:
  - redirect_now = br_valid && (br_taken || br_uncond).
  - target = br_pc + {br_imm[ADDR_W-3:0],2'b00}, truncated to ADDR_W bits, so wrap-around is modulo 2^64.
- State BOOT:
  - imem_req=0.
  - Next cycle goes to FETCH. This gives a one-cycle bubble after reset release.
- State FETCH:
  - imem_req=1.
  - if_valid is asserted only if no redirect_now in the same cycle.
  - On handshake (imem_ready) with no redirect and no stall: pc <= pc+4.
  - Without imem_ready: pc holds and imem_req stays high with a stable address.
- State HOLD:
  - Entered from FETCH when stall=1 and no redirect. imem_req=0 and pc holds.
  - Returns to FETCH the cycle after stall drops.
- Priority is reset > redirect_now > stall > handshake.
- Redirect handling, in any state except BOOT:
  - pc <= target.
  - flush <= 1 for exactly one cycle.
  - The next state is FETCH, even if stall is high.
  - redirect_cnt increments and saturates at all ones.
  - A handshake completing in the same cycle is discarded: if_valid=0 and pc does not advance to pc+4.
- redirect_now in BOOT: captured as above (pc <= target, flush pulse). BOOT still lasts one cycle.
- Back-to-back redirects: each one reloads pc, and flush stays high on consecutive cycles.
- misalign is set when redirect_now && br_pc[1:0]!=0. It clears only on reset. The target is still taken.
- Latency:
  - Redirect to the first fetch at target: 1 cycle.
  - Stall release to request: 1 cycle.
- br_taken with br_valid=0 is ignored.

Decomposition:
- Shared package holds:
  - the state encoding (BOOT=2'd0, FETCH=2'd1, HOLD=2'd2);
  - the PC_STEP=4 constant;
  - ADDR_W.
- One natural sub-module: the existing shift-left-by-2 unit, instantiated to form the branch offset before the adder. The adder and FSM stay inline.

Test Plan:
- Reset release with RESET_PC=0 and imem_ready=1 held → BOOT for 1 cycle, then imem_addr=0,4,8,12 on consecutive cycles with if_valid=1.
- imem_ready low for 3 cycles at pc=8 → imem_req=1 and imem_addr=8 held, if_valid=0; next address is 12 only after ready.
- Stall for 2 cycles at pc=16 → HOLD, imem_req=0, pc=16; FETCH at 16 resumes one cycle after stall drops.
- Redirect with br_pc=0x100, br_imm=-2 (all ones ...FE), br_uncond=1, while stall=1 → next imem_addr=0xF8, flush=1 for one cycle, redirect_cnt=1, stall ignored that cycle.
- Redirect with br_pc=0xFFFF_FFFF_FFFF_FFFC, br_imm=1, br_taken=1 → imem_addr wraps to 0x0. Then br_pc=0x102 → misalign=1, and it stays set until reset.
- Assert reset asynchronously mid-FETCH with imem_ready=1 → all outputs return to reset values immediately (no clock edge needed); redirect_cnt=0.
